// File: rtl/pbtn_event_ctrl.sv
// Pushbutton event sequencer: edge detect, auto-repeat and a one-per-cycle
// priority arbiter feeding a small first-word-fall-through event FIFO.
module pbtn_event_ctrl #(
  parameter int CLK_FREQUENCY_HZ = 50_000_000,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_RATE_MS   = 100,
  parameter int FIFO_DEPTH       = 4,
  parameter int SIMULATE         = 0,
  parameter int SIM_TICK_CNT     = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [5:0]                    pbtn_db,
  input  logic                          enable,
  input  logic                          evt_ready,
  input  logic                          ovf_clr,
  output logic                          evt_valid,
  output logic [4:0]                    evt_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int NBTN     = 6;
  localparam int NPEND    = 3 * NBTN;
  localparam int TICK_TOP = (SIMULATE != 0) ? SIM_TICK_CNT : (CLK_FREQUENCY_HZ / 1000) - 1;
  localparam int TW       = (TICK_TOP > 0) ? $clog2(TICK_TOP + 1) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;

  localparam bit          REP_EN    = (REPEAT_DELAY_MS != 0);
  localparam logic [15:0] DELAY_M1  = REP_EN ? 16'(REPEAT_DELAY_MS - 1) : 16'hFFFF;
  localparam logic [15:0] RELOAD    = REP_EN ? 16'(REPEAT_DELAY_MS - REPEAT_RATE_MS) : 16'h0000;

  // ---------------------------------------------------------------- tick
  logic [TW-1:0] div_q, div_d;
  logic          tick;

  assign tick  = (div_q == TW'(TICK_TOP));
  assign div_d = tick ? '0 : div_q + TW'(1);

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  // ---------------------------------------------------------------- edges
  // prev_db follows the buttons even during reset, so a held button yields no press
  logic [NBTN-1:0] prev_db_q;
  logic [NBTN-1:0] rise, fall, fire;

  always_ff @(posedge clk) begin
    prev_db_q <= pbtn_db;
  end

  assign rise = pbtn_db & ~prev_db_q;
  assign fall = ~pbtn_db & prev_db_q;

  // ---------------------------------------------------------------- repeat
  logic [NPEND-1:0] set_vec;

  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      logic [15:0] hold_q, hold_d;
      logic        fire_g;

      always_comb begin
        hold_d = hold_q;
        fire_g = 1'b0;
        if (!pbtn_db[gi] || rise[gi]) begin
          hold_d = 16'h0000;
        end else if (tick) begin
          if (REP_EN && (hold_q == DELAY_M1)) begin
            fire_g = 1'b1;
            hold_d = RELOAD;
          end else if (hold_q != 16'hFFFF) begin
            hold_d = hold_q + 16'h0001;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) hold_q <= 16'h0000;
        else       hold_q <= hold_d;
      end

      assign fire[gi]          = fire_g;
      assign set_vec[3*gi]     = enable & rise[gi];
      assign set_vec[3*gi + 1] = enable & fall[gi];
      assign set_vec[3*gi + 2] = enable & fire[gi];
    end
  endgenerate

  // ---------------------------------------------------------------- arbiter
  logic [NPEND-1:0] pend_q, pend_d, grant;
  logic [4:0]       push_code;
  logic             push, pop, fifo_full, ovf_hit;
  logic [CW-1:0]    count_q, count_d;

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));

  // bit index 3*btn+type, so the lowest index is the highest priority
  always_comb begin
    grant     = '0;
    push_code = 5'd0;
    push      = 1'b0;
    for (int i = 0; i < NPEND; i++) begin
      if (!push && !fifo_full && pend_q[i]) begin
        grant[i]  = 1'b1;
        push_code = {2'(i % 3), 3'(i / 3)};
        push      = 1'b1;
      end
    end
  end

  assign pend_d  = (pend_q & ~grant) | set_vec;
  assign ovf_hit = |(set_vec & pend_q & ~grant);

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // ---------------------------------------------------------------- overflow
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_hit)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  // ---------------------------------------------------------------- FIFO
  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    code_q, code_d;

  assign pop      = (count_q != '0) && evt_ready;
  assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Head register: when the new head is the entry written this cycle, bypass the array
  always_comb begin
    code_d = code_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) code_d = push_code;
      else                                code_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      code_q   <= 5'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      code_q   <= code_d;
    end
  end

  assign evt_valid  = (count_q != '0);
  assign evt_code   = code_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pbtn_event_ctrl.sv
// Directed bench for pbtn_event_ctrl: per-cycle vector table for the basic edge
// path plus hand sequences for reset, auto-repeat, FIFO-full and overflow cases.
module tb_pbtn_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] pbtn_db;
  logic       enable;
  logic       evt_ready;
  logic       ovf_clr;
  logic       evt_valid;
  logic [4:0] evt_code;
  logic [2:0] fifo_count;
  logic       overflow;

  pbtn_event_ctrl #(
    .CLK_FREQUENCY_HZ(50_000_000),
    .REPEAT_DELAY_MS (3),
    .REPEAT_RATE_MS  (2),
    .FIFO_DEPTH      (4),
    .SIMULATE        (1),
    .SIM_TICK_CNT    (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pbtn_db   (pbtn_db),
    .enable    (enable),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [4:0] q_code [$];
  int         q_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // A handshake seen at the falling edge completes at the next rising edge
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      q_code.push_back(evt_code);
      q_cyc.push_back(cyc);
      $display("[%0d] pop code=0x%02h count=%0d", cyc, evt_code, fifo_count);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [5:0] mask);
    pbtn_db = mask;
    step(2);
    pbtn_db = 6'h00;
    step(3);
  endtask

  task automatic check_queue(input string name, input logic [4:0] exp [$]);
    check({name, "_n"}, q_code.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q_code.size(); i++)
      check($sformatf("%s_%0d", name, i), q_code[i], exp[i]);
  endtask

  typedef struct {
    logic [5:0] pbtn;
    logic       ready;
    logic       exp_valid;
    logic [4:0] exp_code;
    logic [2:0] exp_count;
  } vec_t;

  vec_t vecs [18];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'h01, 1'b1, 1'b0, 5'h0A, 3'd0};
    vecs[1]  = '{6'h01, 1'b1, 1'b0, 5'h0A, 3'd0};
    vecs[2]  = '{6'h01, 1'b1, 1'b1, 5'h00, 3'd1};
    vecs[3]  = '{6'h01, 1'b1, 1'b0, 5'h00, 3'd0};
    vecs[4]  = '{6'h00, 1'b1, 1'b0, 5'h00, 3'd0};
    vecs[5]  = '{6'h00, 1'b1, 1'b0, 5'h00, 3'd0};
    vecs[6]  = '{6'h00, 1'b1, 1'b1, 5'h08, 3'd1};
    vecs[7]  = '{6'h00, 1'b1, 1'b0, 5'h08, 3'd0};
    vecs[8]  = '{6'h12, 1'b1, 1'b0, 5'h08, 3'd0};
    vecs[9]  = '{6'h12, 1'b1, 1'b0, 5'h08, 3'd0};
    vecs[10] = '{6'h12, 1'b1, 1'b1, 5'h01, 3'd1};
    vecs[11] = '{6'h12, 1'b1, 1'b1, 5'h04, 3'd1};
    vecs[12] = '{6'h12, 1'b1, 1'b0, 5'h04, 3'd0};
    vecs[13] = '{6'h00, 1'b1, 1'b0, 5'h04, 3'd0};
    vecs[14] = '{6'h00, 1'b1, 1'b0, 5'h04, 3'd0};
    vecs[15] = '{6'h00, 1'b1, 1'b1, 5'h09, 3'd1};
    vecs[16] = '{6'h00, 1'b1, 1'b1, 5'h0C, 3'd1};
    vecs[17] = '{6'h00, 1'b1, 1'b0, 5'h0C, 3'd0};

    // Reset with pb2 held: no press, only the later release
    reset = 1'b1; pbtn_db = 6'h04; enable = 1'b1; evt_ready = 1'b1; ovf_clr = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    step(1);
    reset = 1'b0;
    step(10);
    check("held_no_press", q_code.size(), 0);
    pbtn_db = 6'h00;
    step(6);
    check_queue("rel_pb2", '{5'h0A});

    // Single press/release and simultaneous presses, cycle by cycle
    for (int i = 0; i < 18; i++) begin
      step(1);
      pbtn_db   = vecs[i].pbtn;
      evt_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), evt_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_code", i), evt_code, vecs[i].exp_code);
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_count);
    end

    // Auto-repeat on a long hold of pb3
    step(1);
    q_code.delete(); q_cyc.delete();
    pbtn_db = 6'h08;
    step(60);
    pbtn_db = 6'h00;
    step(8);
    check_queue("repeat", '{5'h03, 5'h13, 5'h13, 5'h13, 5'h13, 5'h0B});
    if (q_cyc.size() == 6) begin
      check("rep_first_in_range", int'((q_cyc[1] - q_cyc[0]) >= 13 && (q_cyc[1] - q_cyc[0]) <= 18), 1);
      for (int i = 2; i < 5; i++)
        check($sformatf("rep_interval_%0d", i), q_cyc[i] - q_cyc[i-1], 12);
    end
    check("rep_ovf", overflow, 0);

    // Edges while disabled are ignored, and none appear on re-enable
    q_code.delete(); q_cyc.delete();
    enable = 1'b0;
    pulse(6'h20);
    enable = 1'b1;
    step(6);
    check("disabled_none", q_code.size(), 0);

    // FIFO full with pending bits, merge into pending sets overflow
    q_code.delete(); q_cyc.delete();
    evt_ready = 1'b0;
    pulse(6'h04);
    pulse(6'h02);
    pulse(6'h01);
    @(negedge clk);
    check("full_count", fifo_count, 4);
    check("full_ovf", overflow, 0);
    check("full_head", evt_code, 5'h02);
    step(1);
    pulse(6'h01);
    @(negedge clk);
    check("merge_ovf", overflow, 1);
    step(1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", overflow, 0);
    step(1);
    evt_ready = 1'b1;
    step(10);
    check_queue("drain", '{5'h02, 5'h0A, 5'h01, 5'h09, 5'h00, 5'h08});
    check("drain_count", fifo_count, 0);

    // Reset while entries are queued and bits are pending
    evt_ready = 1'b0;
    pbtn_db = 6'h07;
    step(4);
    check("pre_rst_count", fifo_count, 3);
    pbtn_db = 6'h00;
    step(1);
    check("pre_rst_count2", fifo_count, 3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_ovf", overflow, 0);
    q_code.delete(); q_cyc.delete();
    evt_ready = 1'b1;
    step(10);
    check("no_stale", q_code.size(), 0);
    check("no_stale_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
